// File: rtl/ksa_var_pkg.sv
// ksa_var shared types and helpers.
// State encoding, S-array size and key byte selection.
package ksa_pkg;

    localparam int S_SIZE  = 256;
    localparam int KEY_MAX = 32;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RD_I,
        RD_J,
        WR_J,
        WR_I
    } ksa_state_t;

    // Byte idx of a key_bytes-long key held LSB-aligned; byte 0 is the MSB.
    function automatic logic [7:0] key_byte(
        input logic [8*KEY_MAX-1:0] key,
        input logic [4:0]           idx,
        input int                   key_bytes
    );
        return key[8*(key_bytes-1-int'(idx)) +: 8];
    endfunction

endpackage

// File: rtl/ksa_var_if.sv
// ksa_var bus: controller handshake plus S-memory port.
// slave is the engine side, master the controller/memory side.
interface ksa_var_if #(
    parameter int KEY_BYTES = 3
);
    logic                   en;
    logic                   rdy;
    logic [8*KEY_BYTES-1:0] key;
    logic [7:0]             addr;
    logic [7:0]             rddata;
    logic [7:0]             wrdata;
    logic                   wren;

    modport slave (
        input  en, key, rddata,
        output rdy, addr, wrdata, wren
    );

    modport master (
        output en, key, rddata,
        input  rdy, addr, wrdata, wren
    );
endinterface

// File: rtl/ksa_var_keyidx.sv
// Key byte index counter, modulo KEY_BYTES.
// Cleared at start, stepped once per KSA iteration.
module ksa_keyidx #(
    parameter int KEY_BYTES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       step,
    output logic [4:0] idx
);
    logic [4:0] idx_q;
    logic [4:0] idx_d;

    // Next index: clear wins, otherwise wrap at KEY_BYTES-1.
    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (step) begin
            if (idx_q == 5'(KEY_BYTES - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 5'd1;
            end
        end
    end

    // Index register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx = idx_q;
endmodule

// File: rtl/ksa_var.sv
// ARC4 key-scheduling engine with optional identity fill.
// Drives an external 256x8 synchronous S-memory.
module ksa_var
    import ksa_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    parameter int DO_INIT   = 1
) (
    input logic      clk,
    input logic      rst,
    ksa_var_if.slave bus
);
    ksa_state_t             state_q, state_d;
    logic                   rdy_q, rdy_d;
    logic [7:0]             i_q, i_d;
    logic [7:0]             j_q, j_d;
    logic [7:0]             k_q, k_d;
    logic [7:0]             si_q, si_d;
    logic [7:0]             sj_q, sj_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;

    logic [7:0] addr;
    logic [7:0] wrdata;
    logic       wren;
    logic [7:0] jn;
    logic       kidx_clr;
    logic       kidx_step;
    logic [4:0] kidx;

    ksa_keyidx #(.KEY_BYTES(KEY_BYTES)) u_keyidx (
        .clk  (clk),
        .rst  (rst),
        .clr  (kidx_clr),
        .step (kidx_step),
        .idx  (kidx)
    );

    // Next-state and memory-port decode; addr in RD_J follows rddata.
    always_comb begin
        state_d   = state_q;
        rdy_d     = rdy_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        si_d      = si_q;
        sj_d      = sj_q;
        key_d     = key_q;
        addr      = '0;
        wrdata    = '0;
        wren      = 1'b0;
        kidx_clr  = 1'b0;
        kidx_step = 1'b0;
        jn        = j_q + bus.rddata
                  + key_byte((8*KEY_MAX)'(key_q), kidx, KEY_BYTES);
        unique case (state_q)
            IDLE: begin
                if (bus.en) begin
                    key_d    = bus.key;
                    i_d      = '0;
                    j_d      = '0;
                    k_d      = '0;
                    rdy_d    = 1'b0;
                    kidx_clr = 1'b1;
                    state_d  = (DO_INIT != 0) ? INIT : RD_I;
                end
            end
            INIT: begin
                addr   = k_q;
                wrdata = k_q;
                wren   = 1'b1;
                k_d    = k_q + 8'd1;
                if (k_q == 8'(S_SIZE - 1)) begin
                    i_d     = '0;
                    state_d = RD_I;
                end
            end
            RD_I: begin
                addr    = i_q;
                state_d = RD_J;
            end
            RD_J: begin
                si_d    = bus.rddata;
                addr    = jn;
                j_d     = jn;
                state_d = WR_J;
            end
            WR_J: begin
                sj_d    = bus.rddata;
                addr    = j_q;
                wrdata  = si_q;
                wren    = 1'b1;
                state_d = WR_I;
            end
            WR_I: begin
                addr   = i_q;
                wrdata = sj_q;
                wren   = 1'b1;
                if (i_q == 8'(S_SIZE - 1)) begin
                    rdy_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    i_d       = i_q + 8'd1;
                    kidx_step = 1'b1;
                    state_d   = RD_I;
                end
            end
            default: begin
                rdy_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            key_q   <= key_d;
        end
    end

    assign bus.rdy    = rdy_q;
    assign bus.addr   = addr;
    assign bus.wrdata = wrdata;
    assign bus.wren   = wren;
endmodule

// File: tb/tb_ksa_var.sv
// Bench for ksa_var: four parameterisations against S-memory models.
// Expected writes come from a software ARC4 KSA model.
module tb_ksa_var;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   en_v;
    logic [255:0] key_v;
    logic         preload;
    int           active;

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] exp_q[$];
    logic [15:0] wlog[$];
    logic [7:0]  s_model[256];

    logic [7:0] mem_a[256];
    logic [7:0] mem_b[256];
    logic [7:0] mem_c[256];
    logic [7:0] mem_d[256];

    logic       cur_rdy;
    logic       cur_wren;
    logic [7:0] cur_addr;
    logic [7:0] cur_wrdata;

    always #5 clk = ~clk;

    ksa_var_if #(.KEY_BYTES(3)) a_if ();
    ksa_var_if #(.KEY_BYTES(3)) b_if ();
    ksa_var_if #(.KEY_BYTES(1)) c_if ();
    ksa_var_if #(.KEY_BYTES(5)) d_if ();

    assign a_if.en  = en_v[0];
    assign a_if.key = key_v[23:0];
    assign b_if.en  = en_v[1];
    assign b_if.key = key_v[23:0];
    assign c_if.en  = en_v[2];
    assign c_if.key = key_v[7:0];
    assign d_if.en  = en_v[3];
    assign d_if.key = key_v[39:0];

    ksa_var #(.KEY_BYTES(3), .DO_INIT(1)) u_a (
        .clk(clk), .rst(rst), .bus(a_if));
    ksa_var #(.KEY_BYTES(3), .DO_INIT(0)) u_b (
        .clk(clk), .rst(rst), .bus(b_if));
    ksa_var #(.KEY_BYTES(1), .DO_INIT(1)) u_c (
        .clk(clk), .rst(rst), .bus(c_if));
    ksa_var #(.KEY_BYTES(5), .DO_INIT(1)) u_d (
        .clk(clk), .rst(rst), .bus(d_if));

    // Synchronous S-memories, one per engine.
    always @(posedge clk) begin
        if (a_if.wren) mem_a[a_if.addr] <= a_if.wrdata;
        a_if.rddata <= mem_a[a_if.addr];
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 256; k++) mem_b[k] <= 8'(k);
        end else if (b_if.wren) begin
            mem_b[b_if.addr] <= b_if.wrdata;
        end
        b_if.rddata <= mem_b[b_if.addr];
    end

    always @(posedge clk) begin
        if (c_if.wren) mem_c[c_if.addr] <= c_if.wrdata;
        c_if.rddata <= mem_c[c_if.addr];
    end

    always @(posedge clk) begin
        if (d_if.wren) mem_d[d_if.addr] <= d_if.wrdata;
        d_if.rddata <= mem_d[d_if.addr];
    end

    // Observe whichever engine is under test.
    always_comb begin
        cur_rdy    = a_if.rdy;
        cur_wren   = a_if.wren;
        cur_addr   = a_if.addr;
        cur_wrdata = a_if.wrdata;
        case (active)
            1: begin
                cur_rdy    = b_if.rdy;
                cur_wren   = b_if.wren;
                cur_addr   = b_if.addr;
                cur_wrdata = b_if.wrdata;
            end
            2: begin
                cur_rdy    = c_if.rdy;
                cur_wren   = c_if.wren;
                cur_addr   = c_if.addr;
                cur_wrdata = c_if.wrdata;
            end
            3: begin
                cur_rdy    = d_if.rdy;
                cur_wren   = d_if.wren;
                cur_addr   = d_if.addr;
                cur_wrdata = d_if.wrdata;
            end
            default: ;
        endcase
    end

    function automatic logic [7:0] mem_rd(input int inst, input int a);
        case (inst)
            0:       return mem_a[a];
            1:       return mem_b[a];
            2:       return mem_c[a];
            default: return mem_d[a];
        endcase
    endfunction

    function automatic logic [255:0] rkey(input int kb);
        logic [255:0] r;
        r = '0;
        for (int b = 0; b < kb; b++) r[8*b +: 8] = 8'($urandom);
        return r;
    endfunction

    // Software ARC4 KSA from identity; queues every expected write.
    function automatic void ksa_model(
        input logic [255:0] key,
        input int           kb,
        input bit           init
    );
        logic [7:0] j;
        logic [7:0] t;
        logic [7:0] kbyte;
        int         ki;
        for (int k = 0; k < 256; k++) begin
            s_model[k] = 8'(k);
            if (init) exp_q.push_back({8'(k), 8'(k)});
        end
        j = '0;
        for (int i = 0; i < 256; i++) begin
            ki    = i % kb;
            kbyte = key[8*(kb-1-ki) +: 8];
            j     = j + s_model[i] + kbyte;
            t     = s_model[i];
            exp_q.push_back({j, t});
            exp_q.push_back({8'(i), s_model[j]});
            s_model[i] = s_model[j];
            s_model[j] = t;
        end
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    // One clock; scoreboard any memory write seen on the falling edge.
    task automatic tick();
        logic [15:0] e;
        @(negedge clk);
        if (cur_wren) begin
            wlog.push_back({cur_addr, cur_wrdata});
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL extra_write: got addr=%0d data=%0d, want none",
                         cur_addr, cur_wrdata);
            end else begin
                e = exp_q.pop_front();
                if (e != {cur_addr, cur_wrdata}) begin
                    n_bad++;
                    $display("FAIL write%0d: got addr=%0d data=%0d, want addr=%0d data=%0d",
                             wlog.size() - 1, cur_addr, cur_wrdata,
                             e[15:8], e[7:0]);
                end
            end
        end
    endtask

    // Count busy cycles until rdy returns; optionally poke or hold en.
    task automatic wait_done(
        input  int inst,
        input  bit poke,
        input  bit hold,
        output int busy
    );
        busy = 0;
        while (!cur_rdy && busy < 3000) begin
            busy++;
            en_v[inst] = hold || (poke && busy == 300);
            tick();
        end
        if (!hold) en_v[inst] = 1'b0;
        if (busy >= 3000) chk("rdy_timeout", busy, 0);
    endtask

    task automatic check_final(input int inst, input string nm);
        chk({nm, "_exp_left"}, exp_q.size(), 0);
        for (int a = 0; a < 256; a++) begin
            chk($sformatf("%s_s[%0d]", nm, a),
                int'(mem_rd(inst, a)), int'(s_model[a]));
        end
    endtask

    // Full run: start, scramble key after start, wait, check.
    task automatic run(
        input int           inst,
        input int           kb,
        input bit           init,
        input logic [255:0] key,
        input bit           poke,
        input string        nm
    );
        int busy;
        active = inst;
        exp_q.delete();
        wlog.delete();
        if (!init) begin
            preload = 1'b1;
            tick();
            preload = 1'b0;
        end
        ksa_model(key, kb, init);
        key_v      = key;
        en_v[inst] = 1'b1;
        tick();
        en_v[inst] = 1'b0;
        key_v      = ~key;
        wait_done(inst, poke, 1'b0, busy);
        chk({nm, "_busy"}, busy, init ? 1280 : 1024);
        check_final(inst, nm);
    endtask

    wr_vec_t      tbl[6];
    int           busy;
    logic [255:0] k;

    initial begin
        tbl[0] = '{8'd0, 8'd0};
        tbl[1] = '{8'd0, 8'd0};
        tbl[2] = '{8'd1, 8'd1};
        tbl[3] = '{8'd1, 8'd1};
        tbl[4] = '{8'd3, 8'd2};
        tbl[5] = '{8'd2, 8'd3};

        rst     = 1'b1;
        en_v    = '0;
        key_v   = '0;
        preload = 1'b0;
        active  = 0;
        repeat (3) tick();
        chk("rst_rdy", int'(a_if.rdy), 1);
        chk("rst_wren", int'(a_if.wren), 0);
        chk("rst_addr", int'(a_if.addr), 0);
        chk("rst_wrdata", int'(a_if.wrdata), 0);
        rst = 1'b0;
        tick();

        run(0, 3, 1'b1, 256'h0, 1'b0, "a_zero");
        chk("a_zero_nwrites", wlog.size(), 768);
        for (int n = 0; n < 6; n++) begin
            if (wlog.size() > 256 + n) begin
                chk($sformatf("ksa_wr%0d_addr", n),
                    int'(wlog[256+n][15:8]), int'(tbl[n].addr));
                chk($sformatf("ksa_wr%0d_data", n),
                    int'(wlog[256+n][7:0]), int'(tbl[n].data));
            end else begin
                chk($sformatf("ksa_wr%0d_missing", n), 0, 1);
            end
        end

        run(1, 3, 1'b0, 256'h00033C, 1'b1, "b_033c");
        run(2, 1, 1'b1, rkey(1), 1'b0, "c_kb1");
        run(3, 5, 1'b1, rkey(5), 1'b1, "d_kb5");

        // Back-to-back: en held high across completion.
        active = 0;
        exp_q.delete();
        k = rkey(3);
        ksa_model(k, 3, 1'b1);
        ksa_model(k, 3, 1'b1);
        key_v   = k;
        en_v[0] = 1'b1;
        tick();
        wait_done(0, 1'b0, 1'b1, busy);
        chk("b2b_busy1", busy, 1280);
        chk("b2b_rdy_up", int'(cur_rdy), 1);
        tick();
        en_v[0] = 1'b0;
        chk("b2b_restart", int'(cur_rdy), 0);
        wait_done(0, 1'b0, 1'b0, busy);
        chk("b2b_busy2", busy, 1280);
        check_final(0, "b2b");

        // Reset in the middle of a run.
        exp_q.delete();
        k = rkey(3);
        ksa_model(k, 3, 1'b1);
        key_v   = k;
        en_v[0] = 1'b1;
        tick();
        en_v[0] = 1'b0;
        repeat (499) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_rdy", int'(a_if.rdy), 1);
        chk("mid_rst_wren", int'(a_if.wren), 0);
        chk("mid_rst_addr", int'(a_if.addr), 0);
        chk("mid_rst_wrdata", int'(a_if.wrdata), 0);
        tick();
        rst = 1'b0;
        exp_q.delete();
        tick();
        run(0, 3, 1'b1, rkey(3), 1'b0, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ksa_var.md
# ksa_var

Parametrised ARC4 key-scheduling engine: the next-generation KSA for the cracking datapath. It takes a key of KEY_BYTES bytes, optionally fills the S-array with the identity permutation itself, then runs the 256-iteration swap schedule against an external 256×8 synchronous S-memory. It sits between the crack controller (en/rdy handshake) and the S-memory port, replacing the separate init-plus-fixed-24-bit-KSA pair.

## Interface
Parameters:
- KEY_BYTES, default 3: key length in bytes, legal range 1..32.
- DO_INIT, default 1: 1 runs the identity fill s[k]=k before the KSA; 0 runs the KSA only.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: start request; honoured only in a cycle where rdy=1.
- rdy, output, 1: idle and ready for a new start.
- key, input, 8*KEY_BYTES: key; byte b = key[8*KEY_BYTES-1-8b -: 8], so byte 0 is the MSB.
- addr, output, 8: S-memory address.
- rddata, input, 8: S-memory read data; valid the cycle after addr is presented.
- wrdata, output, 8: S-memory write data.
- wren, output, 1: S-memory write enable.

## Operation
- States: IDLE, INIT, RD_I, RD_J, WR_J, WR_I.
- IDLE: rdy=1, wren=0. On en=1 the block latches key into key_q, clears i and j, and moves to INIT (DO_INIT=1) or RD_I (DO_INIT=0).
- INIT, counter k = 0..255: drive addr=k, wrdata=k, wren=1. After k=255, go to RD_I with i=0.
- RD_I: drive addr=i, wren=0.
- RD_J: rddata holds s[i]; register si=rddata.
  - Compute jn = (j + rddata + key_q byte (i mod KEY_BYTES)) mod 256; all adds are 8-bit and wrap.
  - Drive addr=jn and register j=jn.
- WR_J: rddata holds s[j]; register sj=rddata. Drive addr=j, wrdata=si, wren=1.
- WR_I: drive addr=i, wrdata=sj, wren=1.
  - If i=255, go to IDLE.
  - Otherwise increment i and go to RD_I.
- Key index: a separate modulo counter, reset to 0 at start and wrapping at KEY_BYTES-1. No divider is used.
- Case i==j: the two writes carry the same value, so S is unchanged. No special case is needed.
- en while rdy=0 is ignored. Key changes after the start cycle have no effect.
- A read and a write never occur in the same cycle, so there is no read-during-write hazard.

## Timing
- Reset values: state=IDLE, rdy=1, wren=0, addr=0, wrdata=0; i, j, k, si, sj and key_q all 0.
- Reset asserted mid-run aborts immediately to IDLE with the reset values. Memory contents are undefined afterwards.
- rdy, state and the registered values are flopped. addr, wrdata and wren are combinational from the state and registers. The one exception is addr in RD_J, which depends combinationally on rddata.
- Start: en sampled high at edge E makes rdy=0 from E onward. The first INIT or RD_I cycle is the cycle after E.
- Durations:
  - INIT: exactly 256 cycles.
  - KSA: 4 cycles per i, 1024 cycles total.
  - Busy time: 1280 cycles with DO_INIT=1, 1024 cycles with DO_INIT=0. rdy returns to 1 in the cycle after the final WR_I.
- Back-to-back: en held high across completion starts a new run at the first rdy=1 edge, with zero idle cycles.

## Structure
- Package ksa_pkg holds:
  - the state enum ksa_state_t;
  - the constant S_SIZE=256;
  - the function key_byte(key, idx, KEY_BYTES).
- Natural sub-module: ksa_keyidx, the modulo-KEY_BYTES byte-index counter with clear and step inputs.
- Everything else stays in a single always_ff plus always_comb pair.

## Test plan
- DO_INIT=1, KEY_BYTES=3, key=24'h000000. Memory model checks:
  - The INIT cycles write (k,k) for k=0..255.
  - The first six KSA writes (addr,data) are (0,0),(0,0),(1,1),(1,1),(3,2),(2,3).
  - rdy is 0 for exactly 1280 cycles.
- DO_INIT=0, KEY_BYTES=3, memory preloaded with identity, key=24'h00033C. The final S-array matches the software ARC4 KSA model byte-for-byte.
- KEY_BYTES=1 and KEY_BYTES=5 with random keys: the final S matches the model. This checks key-index wrap at 1 and at a non-power-of-2 length.
- Handshake:
  - en pulsed while busy: no effect, and the cycle count is unchanged.
  - key changed mid-run: the result still matches the key latched at start.
  - en held high: the second run starts the cycle rdy rises.
- Reset check: assert rst at cycle 500 of a run.
  - Outputs return at once to rdy=1, wren=0, addr=0, wrdata=0.
  - A following en gives a correct full run.
